// File: rtl/ef_tmr32_icap.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module : ef_tmr32_icap                                                       |
// | Brief  : timer input capture - sync/de-glitch, edge stamp FIFO, period delta |
// | Rev    : 1.0                                                                 |
// +-----------------------------------------------------------------------------+
module ef_tmr32_icap #(
  parameter int AW    = 2,
  parameter int FLT_N = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [31:0] tmr,
  input  logic        cap_in,
  input  logic [1:0]  edge_sel,
  input  logic        flt_en,
  input  logic        rd,
  input  logic        ovf_clr,
  output logic [31:0] cap_data,
  output logic        cap_pol,
  output logic        empty,
  output logic        full,
  output logic [AW:0] level,
  output logic        ovf,
  output logic [31:0] cap_delta,
  output logic        delta_vld
);

  localparam int            c_depth_i = 1 << AW;
  localparam logic [AW:0]   c_depth   = (AW+1)'(c_depth_i);
  localparam logic [7:0]    c_run_max = 8'(FLT_N - 1);
  localparam logic [AW-1:0] c_ptr_one = AW'(1);

  logic          r_sync1, r_sync2, r_flt, r_prev;
  logic [7:0]    r_run;
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_level;
  logic [32:0]   r_mem [c_depth_i];
  logic [32:0]   r_head;
  logic          r_ovf, r_dvld, r_seen;
  logic [31:0]   r_delta, r_prev_stamp;

  logic          w_f, w_rise, w_fall, w_cap, w_push, w_pop, w_drop;
  logic [AW:0]   w_lvl_mid;
  logic [AW-1:0] w_rp_nxt;

  assign w_f    = flt_en ? r_flt : r_sync2;
  assign w_rise = w_f & ~r_prev;
  assign w_fall = ~w_f & r_prev;
  assign w_cap  = en & ((w_rise & edge_sel[0]) | (w_fall & edge_sel[1]));

  assign full   = (r_level == c_depth);
  assign empty  = (r_level == '0);
  assign w_push = w_cap & (~full | rd);
  assign w_pop  = rd & ~empty;
  assign w_drop = w_cap & full & ~rd;

  assign w_lvl_mid = r_level - (AW+1)'(w_pop);
  assign w_rp_nxt  = w_pop ? (r_rp + c_ptr_one) : r_rp;

  // Filter follows s while bypassed so enabling it never starts from a stale level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_flt   <= 1'b0;
      r_run   <= '0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= cap_in;
      r_sync2 <= r_sync1;
      r_prev  <= w_f;
      if (!flt_en) begin
        r_flt <= r_sync2;
        r_run <= '0;
      end else if (r_sync2 == r_flt) begin
        r_run <= '0;
      end else if (r_run == c_run_max) begin
        r_flt <= r_sync2;
        r_run <= '0;
      end else begin
        r_run <= r_run + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= {w_f, tmr};
  end

  // r_head pre-loads the next head so the output holds its value once drained
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_level <= '0;
      r_head  <= '0;
    end else if (!en) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + c_ptr_one;
      r_rp    <= w_rp_nxt;
      r_level <= r_level + (AW+1)'(w_push) - (AW+1)'(w_pop);
      if (w_push || (w_lvl_mid != '0)) begin
        if (w_lvl_mid == '0) r_head <= {w_f, tmr};
        else                 r_head <= r_mem[w_rp_nxt];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_delta      <= '0;
      r_prev_stamp <= '0;
      r_dvld       <= 1'b0;
      r_seen       <= 1'b0;
    end else if (!en) begin
      r_prev_stamp <= '0;
      r_dvld       <= 1'b0;
      r_seen       <= 1'b0;
    end else if (w_cap) begin
      r_delta      <= tmr - r_prev_stamp;
      r_prev_stamp <= tmr;
      r_dvld       <= r_seen;
      r_seen       <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_ovf <= 1'b0;
    else if (w_drop)  r_ovf <= 1'b1;
    else if (ovf_clr) r_ovf <= 1'b0;
  end

  assign cap_data  = r_head[31:0];
  assign cap_pol   = r_head[32];
  assign level     = r_level;
  assign ovf       = r_ovf;
  assign cap_delta = r_delta;
  assign delta_vld = r_dvld;

endmodule
`default_nettype wire
